// File: rtl/round_scorer_pkg.sv
// Shared definitions for the round scorer and the downstream score tracker / display blocks.
package round_scorer_pkg;

  localparam int SCORE_W           = 7;
  localparam int PID_W             = 3;
  localparam int SCORE_MAX_DEFAULT = 99;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_REPORT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/round_scorer_score_sat_acc.sv
// Clamped score accumulator: adds HIT_PTS per hit, subtracts MISS_PTS per miss, saturates to [0, SCORE_MAX].
module score_sat_acc
  import round_scorer_pkg::*;
#(
  parameter int HIT_PTS   = 3,
  parameter int MISS_PTS  = 1,
  parameter int SCORE_MAX = SCORE_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic               hit,
  input  logic               miss,
  output logic [SCORE_W-1:0] score
);

  logic signed [8:0]   delta;
  logic signed [8:0]   sum;
  logic [SCORE_W-1:0]  next_score;

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    delta = 9'sd0;
    if (hit)  delta = delta + 9'(HIT_PTS);
    if (miss) delta = delta - 9'(MISS_PTS);
    sum = $signed({2'b00, score}) + delta;
    if (sum < 9'sd0)
      next_score = '0;
    else if (sum > 9'(SCORE_MAX))
      next_score = SCORE_W'(SCORE_MAX);
    else
      next_score = sum[SCORE_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        score <= '0;
    else if (clear)  score <= '0;
    else if (enable) score <= next_score;
  end

endmodule

// File: rtl/round_scorer.sv
// Timed game round per player: accumulates a clamped score, emits one score request, then holds off.
module round_scorer
  import round_scorer_pkg::*;
#(
  parameter int ROUND_TICKS = 30,
  parameter int HIT_PTS     = 3,
  parameter int MISS_PTS    = 1,
  parameter int SCORE_MAX   = SCORE_MAX_DEFAULT,
  parameter int GAP_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PID_W-1:0]   player_id_in,
  input  logic               guest_in,
  input  logic               tick,
  input  logic               hit,
  input  logic               miss,
  output logic               score_req,
  output logic [PID_W-1:0]   PlayerID,
  output logic               isGuest,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         time_left,
  output logic               round_active,
  output logic               busy
);

  localparam int HOLD_W = $clog2(GAP_CYCLES);

  state_t              state;
  state_t              next_state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                accept;
  logic                round_end;

  assign accept    = (state == ST_IDLE) && start;
  assign round_end = (state == ST_PLAY) && tick && (time_left == 8'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (accept) next_state = ST_PLAY;
      ST_PLAY:    if (round_end) next_state = ST_REPORT;
      ST_REPORT:  next_state = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_cnt == '0) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    score_req    = (state == ST_REPORT);
    round_active = (state == ST_PLAY);
    busy         = (state != ST_IDLE);
  end

  // Round context and timers; all hold their values outside the states that touch them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PlayerID  <= '0;
      isGuest   <= 1'b0;
      time_left <= '0;
      hold_cnt  <= '0;
    end else begin
      if (accept) begin
        PlayerID  <= player_id_in;
        isGuest   <= guest_in;
        time_left <= 8'(ROUND_TICKS);
      end else if (state == ST_PLAY && tick) begin
        time_left <= time_left - 8'd1;
      end
      if (state == ST_REPORT)
        hold_cnt <= HOLD_W'(GAP_CYCLES - 1);
      else if (state == ST_HOLDOFF && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  score_sat_acc #(
    .HIT_PTS   (HIT_PTS),
    .MISS_PTS  (MISS_PTS),
    .SCORE_MAX (SCORE_MAX)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state == ST_PLAY),
    .hit    (hit),
    .miss   (miss),
    .score  (score)
  );

endmodule

// File: tb/tb_round_scorer.sv
// Directed self-checking bench for round_scorer with default parameters.
module tb_round_scorer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] player_id_in = 3'd0;
  logic       guest_in = 1'b0;
  logic       tick = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       score_req;
  logic [2:0] PlayerID;
  logic       isGuest;
  logic [6:0] score;
  logic [7:0] time_left;
  logic       round_active;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int req_count = 0;
  bit done;

  round_scorer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .player_id_in (player_id_in),
    .guest_in     (guest_in),
    .tick         (tick),
    .hit          (hit),
    .miss         (miss),
    .score_req    (score_req),
    .PlayerID     (PlayerID),
    .isGuest      (isGuest),
    .score        (score),
    .time_left    (time_left),
    .round_active (round_active),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (score_req) req_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given pulses; returns 1 time unit after the edge.
  task automatic cyc(input logic s, input logic t, input logic h, input logic m);
    start = s; tick = t; hit = h; miss = m;
    @(posedge clk);
    #1;
    start = 1'b0; tick = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      cyc(0, 0, 0, 0);
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #12 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_score_req", 32'(score_req), 0);
    check("rst_pid", 32'(PlayerID), 0);
    check("rst_guest", 32'(isGuest), 0);
    check("rst_score", 32'(score), 0);
    check("rst_time_left", 32'(time_left), 0);
    check("rst_active", 32'(round_active), 0);
    check("rst_busy", 32'(busy), 0);

    // Idle ignores scoring pulses.
    cyc(0, 1, 1, 0);
    check("idle_ignore_hit", 32'(score), 0);
    check("idle_ignore_tick", 32'(time_left), 0);

    // Round 1: id 5, hits on ticks 1,2,3 and on the final tick 30 -> 12.
    player_id_in = 3'd5; guest_in = 1'b0;
    cyc(1, 0, 0, 0);
    check("r1_active", 32'(round_active), 1);
    check("r1_pid", 32'(PlayerID), 5);
    check("r1_time_load", 32'(time_left), 30);
    check("r1_score_clear", 32'(score), 0);
    for (int t = 1; t <= 29; t++) cyc(0, 1, (t <= 3), 0);
    check("r1_time_one", 32'(time_left), 1);
    check("r1_score_pre", 32'(score), 9);
    check("r1_no_req_yet", 32'(req_count), 0);
    cyc(0, 1, 1, 0);
    check("r1_req", 32'(score_req), 1);
    check("r1_final_score", 32'(score), 12);
    check("r1_req_pid", 32'(PlayerID), 5);
    check("r1_req_guest", 32'(isGuest), 0);
    check("r1_time_zero", 32'(time_left), 0);

    // Hold-off: starts at +5 and +17 edges (last HOLDOFF cycle) are dropped.
    for (int k = 1; k <= 17; k++) begin
      player_id_in = 3'd7;
      cyc((k == 5) || (k == 17), 0, 0, 0);
      if (k == 1) check("r1_req_single", 32'(score_req), 0);
      if (k == 6) check("holdoff_start_ignored", 32'(round_active), 0);
      if (k == 16) check("holdoff_busy", 32'(busy), 1);
    end
    check("holdoff_done_idle", 32'(busy), 0);
    check("late_start_not_queued", 32'(round_active), 0);
    check("r1_req_count", 32'(req_count), 1);
    check("hold_pid_kept", 32'(PlayerID), 5);

    // Round 2: start accepted GAP_CYCLES+1 cycles after score_req; saturation.
    player_id_in = 3'd2; guest_in = 1'b1;
    cyc(1, 0, 0, 0);
    check("r2_accepted", 32'(round_active), 1);
    check("r2_guest", 32'(isGuest), 1);
    player_id_in = 3'd6; guest_in = 1'b0;
    cyc(1, 0, 1, 0);
    check("play_start_ignored_pid", 32'(PlayerID), 2);
    check("play_start_ignored_score", 32'(score), 3);
    for (int i = 0; i < 39; i++) cyc(0, 0, 1, 0);
    check("r2_saturate", 32'(score), 99);
    for (int t = 1; t <= 30; t++) cyc(0, 1, 1, 0);
    check("r2_req", 32'(score_req), 1);
    check("r2_req_score", 32'(score), 99);
    check("r2_req_pid", 32'(PlayerID), 2);
    check("r2_req_guest", 32'(isGuest), 1);
    wait_idle("r2_idle_bound");
    check("r2_req_count", 32'(req_count), 2);

    // Round 3: floor clamp, net delta, then async reset mid-round.
    player_id_in = 3'd1; guest_in = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("r3_floor", 32'(score), 0);
    cyc(0, 0, 1, 1);
    check("r3_net_delta", 32'(score), 2);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    for (int t = 0; t < 20; t++) cyc(0, 1, 0, 0);
    check("r3_pre_rst_time", 32'(time_left), 10);
    check("r3_pre_rst_score", 32'(score), 9);
    #2 rst = 1'b0;
    #1;
    check("arst_score", 32'(score), 0);
    check("arst_time", 32'(time_left), 0);
    check("arst_active", 32'(round_active), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_pid", 32'(PlayerID), 0);
    cyc(0, 0, 0, 0);
    #3 rst = 1'b1;
    for (int t = 0; t < 30; t++) cyc(0, 1, 0, 0);
    check("arst_no_req", 32'(req_count), 2);
    check("arst_stays_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_scorer.md
Name: round_scorer

Overview:
- Upstream feeder of the score-tracking stage: runs one timed game round per player, accumulates a clamped 7-bit score from hit/miss pulses, then issues a single-cycle score request carrying player ID, guest flag and final score.
- The consumer has no acknowledge and samples requests only while idle, so this block enforces a fixed hold-off after every request.

Parameters:
- ROUND_TICKS, 30, tick pulses per round (1..255)
- HIT_PTS, 3, points added per hit (1..15)
- MISS_PTS, 1, points subtracted per miss (0..15)
- SCORE_MAX, 99, score saturation ceiling (must be <= 127)
- GAP_CYCLES, 16, idle clocks after score_req before a new round may start (>= 8; covers the consumer's worst-case 8-cycle path)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  round-start pulse, already debounced
- player_id_in  in  3  player selecting the round
- guest_in  in  1  guest round (no personal-best lookup downstream)
- tick  in  1  one-cycle timebase enable
- hit  in  1  one-cycle correct-hit pulse
- miss  in  1  one-cycle miss pulse
- score_req  out  1  one-cycle request to score tracker
- PlayerID  out  3  latched player ID, stable from PLAY through end of HOLDOFF
- isGuest  out  1  latched guest flag, same stability
- score  out  7  running/final score
- time_left  out  8  ticks remaining in round
- round_active  out  1  high in PLAY
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst=0): state IDLE; score_req=0, PlayerID=0, isGuest=0, score=0, time_left=0, round_active=0, busy=0; hold-off counter 0. Reset mid-round or mid-hold-off abandons the round; no score_req is emitted.
- States: IDLE, PLAY, REPORT, HOLDOFF.
- IDLE: on start=1, latch player_id_in and guest_in, clear score to 0, load time_left=ROUND_TICKS, go to PLAY on the next edge. hit, miss and tick are ignored in IDLE.
- PLAY (round_active=1): each cycle compute delta = (hit ? HIT_PTS : 0) - (miss ? MISS_PTS : 0) in signed 9-bit arithmetic. Update score = clamp(score + delta, 0, SCORE_MAX).
  - Simultaneous hit and miss apply the net delta in one cycle.
  - On tick, time_left decrements.
  - If tick arrives while time_left==1, the round ends: that cycle's hit/miss still counts, time_left becomes 0, next state is REPORT.
  - start is ignored in PLAY.
- REPORT: score_req=1 for exactly one cycle. score, PlayerID and isGuest hold the final values. Next state is HOLDOFF with the counter loaded to GAP_CYCLES-1.
- HOLDOFF: outputs hold, counter decrements, go to IDLE when the counter reaches 0. start is ignored (dropped, not queued).
- Latency: the last scoring tick reaches score_req 1 cycle later. The earliest next round begins GAP_CYCLES+1 cycles after score_req.
- score is registered; it never exceeds SCORE_MAX and never underflows below 0 (clamp before write).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/PLAY/REPORT/HOLDOFF)
  - score width (7) and player-ID width (3)
  - default SCORE_MAX
  These are reused by the score tracker and display blocks.
- One natural sub-module, score_sat_acc: the clamped signed add/subtract accumulator (clear, hit, miss in; 7-bit score out).

Test Plan:
- Reset then start with id=5, guest=0, and 4 hits over 30 ticks -> exactly one score_req pulse with PlayerID=5, isGuest=0, score=12, one cycle after the 30th tick.
- 40 hits in one round with SCORE_MAX=99 -> score saturates at 99 and stays there; score_req carries 99.
- 2 misses at score 0, then hit and miss in the same cycle -> score stays 0, then becomes 2.
- start pulsed during PLAY and again during HOLDOFF -> both ignored; a start pulsed exactly GAP_CYCLES+1 cycles after score_req is accepted.
- rst asserted asynchronously mid-PLAY, with time_left=10 and score=9 -> all outputs 0 immediately; no score_req ever appears for that round.
- Hit coincident with the final tick -> counted; the reported score includes +3.
